masked_sbox_scheduler: RTL and testbench

Sequencer for the single shared masked S-box inverter pipeline in the AES core, which has a fixed LATENCY. Two requesters share it: the round datapath (16 state bytes per batch) and the key schedule (4 SubWord bytes per batch). The block selects one byte per cycle for the inverter input and tracks in-flight bytes with a tag delay line. It tells each requester which byte index to write back, and when its batch has finished.

---
 rtl/masked_sbox_scheduler_pkg.sv | 27 ++
 rtl/masked_sbox_scheduler_if.sv | 34 +++
 rtl/masked_sbox_scheduler_tag_pipe.sv | 40 ++++
 rtl/masked_sbox_scheduler.sv | 126 ++++++++++++
 tb/tb_masked_sbox_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/masked_sbox_scheduler_pkg.sv
// Shared types for the masked S-box scheduler: byte source, in-flight tag
// and the issue-sequencer state encoding.
package masked_sbox_scheduler_pkg;

  // Width of a byte index tag; covers the 16 state bytes.
  localparam int IDX_W = 4;

  typedef enum logic {
    SRC_STATE = 1'b0,
    SRC_KEY   = 1'b1
  } sbox_src_t;

  typedef struct packed {
    logic             valid;
    sbox_src_t        src;
    logic [IDX_W-1:0] idx;
  } sbox_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE_KEY   = 2'd1,
    ST_ISSUE_STATE = 2'd2
  } sched_state_t;

  localparam sbox_tag_t TAG_NONE = '{valid: 1'b0, src: SRC_STATE, idx: '0};

endpackage

// File: rtl/masked_sbox_scheduler_if.sv
// Request / issue / writeback bundle between the scheduler and its users
// (round datapath, key schedule, inverter input mux).
interface masked_sbox_scheduler_if;

  logic                                        in_state_req;
  logic                                        in_key_req;
  logic                                        out_issue_valid;
  logic                                        out_issue_src;
  logic [masked_sbox_scheduler_pkg::IDX_W-1:0] out_issue_idx;
  logic                                        out_wb_valid;
  logic                                        out_wb_src;
  logic [masked_sbox_scheduler_pkg::IDX_W-1:0] out_wb_idx;
  logic                                        out_state_done;
  logic                                        out_key_done;
  logic                                        out_busy;
  logic                                        out_overrun;

  // Requesters / surrounding datapath side.
  modport master (
    output in_state_req, in_key_req,
    input  out_issue_valid, out_issue_src, out_issue_idx,
    input  out_wb_valid, out_wb_src, out_wb_idx,
    input  out_state_done, out_key_done, out_busy, out_overrun
  );

  // Scheduler side.
  modport slave (
    input  in_state_req, in_key_req,
    output out_issue_valid, out_issue_src, out_issue_idx,
    output out_wb_valid, out_wb_src, out_wb_idx,
    output out_state_done, out_key_done, out_busy, out_overrun
  );

endinterface

// File: rtl/masked_sbox_scheduler_tag_pipe.sv
// DEPTH-stage shift register of byte tags that runs alongside the masked
// inverter, so each inverter output arrives labelled with its source/index.
module masked_sbox_tag_pipe
  import masked_sbox_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sbox_tag_t tag_i,
  output sbox_tag_t tag_o,
  output logic      any_valid_o
);

  sbox_tag_t stage_q [DEPTH];

  // Shift a new tag in every cycle; the last stage lines up with the inverter output.
  // NOTE: non-blocking assignments make every stage sample the previous stage's
  // old value, which is what a shift register needs; blocking would collapse it.
  // NOTE: every stage is cleared by reset, so tags of an aborted batch can never
  // reach writeback and raise a spurious done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Any tagged byte still inside the inverter keeps the scheduler busy.
  // NOTE: the default before the loop keeps this purely combinational (no latch).
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid_o = any_valid_o | stage_q[i].valid;
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/masked_sbox_scheduler.sv
// Issue sequencer for the shared masked S-box inverter. Arbitrates state and
// key batches (key first, non-preemptive), issues one byte index per cycle
// and tracks in-flight bytes so requesters know where and when to write back.
// LATENCY must equal the inverter's pipeline depth (3 or 4).
module masked_sbox_scheduler
  import masked_sbox_scheduler_pkg::*;
#(
  parameter int LATENCY         = 4,
  parameter int NUM_STATE_BYTES = 16,
  parameter int NUM_KEY_BYTES   = 4
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  masked_sbox_scheduler_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_STATE = IDX_W'(NUM_STATE_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_KEY   = IDX_W'(NUM_KEY_BYTES - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             state_pend_q, state_pend_d;
  logic             key_pend_q, key_pend_d;
  logic             overrun_q, overrun_d;

  logic issuing_state, issuing_key, last_issue;
  logic state_ovr, key_ovr, state_acc, key_acc;
  logic state_cand, key_cand;

  sbox_tag_t issue_tag, wb_tag;
  logic      tags_in_flight;

  assign issuing_state = (state_q == ST_ISSUE_STATE);
  assign issuing_key   = (state_q == ST_ISSUE_KEY);
  assign last_issue    = (issuing_key && cnt_q == LAST_KEY) ||
                         (issuing_state && cnt_q == LAST_STATE);

  // A request for a source that is already queued or mid-issue is dropped.
  assign state_ovr = bus.in_state_req & (state_pend_q | issuing_state);
  assign key_ovr   = bus.in_key_req   & (key_pend_q   | issuing_key);
  assign state_acc = bus.in_state_req & ~state_ovr;
  assign key_acc   = bus.in_key_req   & ~key_ovr;

  // Registered sequencer state, pending flags, index counter and error flag.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      state_pend_q <= 1'b0;
      key_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      state_pend_q <= state_pend_d;
      key_pend_q   <= key_pend_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state: advance the batch, or at a batch boundary pick the next source.
  // When idle a fresh request starts at once; at the last issue cycle only
  // requests already latched in the pending flags are considered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    state_pend_d = state_pend_q | state_acc;
    key_pend_d   = key_pend_q | key_acc;
    overrun_d    = overrun_q | state_ovr | key_ovr;
    state_cand   = 1'b0;
    key_cand     = 1'b0;

    if (state_q == ST_IDLE) begin
      key_cand   = key_pend_q | key_acc;
      state_cand = state_pend_q | state_acc;
    end else if (last_issue) begin
      key_cand   = key_pend_q;
      state_cand = state_pend_q;
    end

    if (state_q != ST_IDLE && !last_issue) begin
      cnt_d = cnt_q + 1'b1;
    end else if (key_cand) begin
      state_d    = ST_ISSUE_KEY;
      cnt_d      = '0;
      key_pend_d = 1'b0;
    end else if (state_cand) begin
      state_d      = ST_ISSUE_STATE;
      cnt_d        = '0;
      state_pend_d = 1'b0;
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Issue outputs decode straight from registers, never from the requests.
  assign issue_tag = '{valid: (state_q != ST_IDLE),
                       src:   sbox_src_t'(issuing_key),
                       idx:   cnt_q};

  masked_sbox_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk         (in_clock),
    .rst_n       (in_reset),
    .tag_i       (issue_tag),
    .tag_o       (wb_tag),
    .any_valid_o (tags_in_flight)
  );

  assign bus.out_issue_valid = issue_tag.valid;
  assign bus.out_issue_src   = issue_tag.src;
  assign bus.out_issue_idx   = issue_tag.idx;

  assign bus.out_wb_valid = wb_tag.valid;
  assign bus.out_wb_src   = wb_tag.src;
  assign bus.out_wb_idx   = wb_tag.idx;

  assign bus.out_state_done = wb_tag.valid && (wb_tag.src == SRC_STATE) && (wb_tag.idx == LAST_STATE);
  assign bus.out_key_done   = wb_tag.valid && (wb_tag.src == SRC_KEY)   && (wb_tag.idx == LAST_KEY);

  assign bus.out_busy    = state_pend_q | key_pend_q | issue_tag.valid | tags_in_flight;
  assign bus.out_overrun = overrun_q;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Self-checking bench for masked_sbox_scheduler. Two instances (LATENCY 4 and
// 3) receive identical request streams and are compared every cycle against a
// batch-schedule reference model; directed scenarios also pin done cycles.
module tb_masked_sbox_scheduler;

  localparam int NS   = 16;
  localparam int NK   = 4;
  localparam int MAXC = 400;

  typedef struct packed {
    logic       iv;
    logic       isrc;
    logic [3:0] iidx;
    logic       wv;
    logic       wsrc;
    logic [3:0] widx;
    logic       sd;
    logic       kd;
    logic       busy;
    logic       ovr;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_sbox_scheduler_if bus4 ();
  masked_sbox_scheduler_if bus3 ();

  masked_sbox_scheduler #(.LATENCY(4), .NUM_STATE_BYTES(NS), .NUM_KEY_BYTES(NK)) dut4 (
    .in_clock (clk),
    .in_reset (rst_n),
    .bus      (bus4.slave)
  );

  masked_sbox_scheduler #(.LATENCY(3), .NUM_STATE_BYTES(NS), .NUM_KEY_BYTES(NK)) dut3 (
    .in_clock (clk),
    .in_reset (rst_n),
    .bus      (bus3.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Request stimulus per cycle and the model's expected issue schedule.
  bit rq_s    [MAXC];
  bit rq_k    [MAXC];
  bit ex_v    [MAXC];
  bit ex_src  [MAXC];
  int ex_idx  [MAXC];
  bit ex_pend [MAXC];
  int ovr_from;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input bit k);
    bus4.in_state_req = s;
    bus4.in_key_req   = k;
    bus3.in_state_req = s;
    bus3.in_key_req   = k;
  endtask

  function automatic obs_t get_obs(input int lat);
    obs_t o;
    if (lat == 4) begin
      o = '{bus4.out_issue_valid, bus4.out_issue_src, bus4.out_issue_idx,
            bus4.out_wb_valid, bus4.out_wb_src, bus4.out_wb_idx,
            bus4.out_state_done, bus4.out_key_done, bus4.out_busy, bus4.out_overrun};
    end else begin
      o = '{bus3.out_issue_valid, bus3.out_issue_src, bus3.out_issue_idx,
            bus3.out_wb_valid, bus3.out_wb_src, bus3.out_wb_idx,
            bus3.out_state_done, bus3.out_key_done, bus3.out_busy, bus3.out_overrun};
    end
    return o;
  endfunction

  task automatic cmp(input string p, input obs_t o, input obs_t e);
    check({p, " issue_valid"}, 32'(o.iv),   32'(e.iv));
    check({p, " issue_src"},   32'(o.isrc), 32'(e.isrc));
    check({p, " issue_idx"},   32'(o.iidx), 32'(e.iidx));
    check({p, " wb_valid"},    32'(o.wv),   32'(e.wv));
    check({p, " wb_src"},      32'(o.wsrc), 32'(e.wsrc));
    check({p, " wb_idx"},      32'(o.widx), 32'(e.widx));
    check({p, " state_done"},  32'(o.sd),   32'(e.sd));
    check({p, " key_done"},    32'(o.kd),   32'(e.kd));
    check({p, " busy"},        32'(o.busy), 32'(e.busy));
    check({p, " overrun"},     32'(o.ovr),  32'(e.ovr));
  endtask

  // A request that arrived at cycle a may start a batch at cycle c only if it
  // was latched before the decision cycle c-1, unless c-1 was an idle cycle.
  function automatic bit can_start(input int a, input int c, input int last_end);
    return (a <= c - 1) && !(a == c - 1 && last_end == c - 1);
  endfunction

  // Reference model: schedules whole batches on a timeline from the request trace.
  task automatic build_model(input int ncyc);
    int batch_end   = -1;
    int batch_start = 0;
    bit batch_key   = 1'b0;
    bit pk = 1'b0, ps = 1'b0;
    int ak = 0, as_ = 0;
    ovr_from = MAXC + 1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > batch_end) begin
        if (pk && can_start(ak, c, batch_end)) begin
          batch_key = 1'b1; batch_start = c; batch_end = c + NK - 1; pk = 1'b0;
        end else if (ps && can_start(as_, c, batch_end)) begin
          batch_key = 1'b0; batch_start = c; batch_end = c + NS - 1; ps = 1'b0;
        end
      end
      ex_v[c]    = (c <= batch_end);
      ex_src[c]  = ex_v[c] ? batch_key : 1'b0;
      ex_idx[c]  = ex_v[c] ? (c - batch_start) : 0;
      ex_pend[c] = pk | ps;
      if (rq_k[c]) begin
        if (pk || (ex_v[c] && batch_key)) begin
          if (c + 1 < ovr_from) ovr_from = c + 1;
        end else begin
          pk = 1'b1; ak = c;
        end
      end
      if (rq_s[c]) begin
        if (ps || (ex_v[c] && !batch_key)) begin
          if (c + 1 < ovr_from) ovr_from = c + 1;
        end else begin
          ps = 1'b1; as_ = c;
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int lat, input int c);
    obs_t e = '0;
    int   w = c - lat;
    e.iv   = ex_v[c];
    e.isrc = ex_src[c];
    e.iidx = 4'(ex_idx[c]);
    if (w >= 0 && ex_v[w]) begin
      e.wv   = 1'b1;
      e.wsrc = ex_src[w];
      e.widx = 4'(ex_idx[w]);
      e.sd   = !ex_src[w] && (ex_idx[w] == NS - 1);
      e.kd   =  ex_src[w] && (ex_idx[w] == NK - 1);
    end
    e.busy = ex_pend[c] | ex_v[c];
    for (int j = 1; j <= lat; j++)
      if (c - j >= 0 && ex_v[c-j]) e.busy = 1'b1;
    e.ovr = (c >= ovr_from);
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    cmp("reset L4", get_obs(4), '0);
    cmp("reset L3", get_obs(3), '0);
    rst_n = 1'b1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      rq_s[c] = 1'b0;
      rq_k[c] = 1'b0;
    end
  endtask

  // Runs one scenario from a fresh reset; cycle 0 begins at the first rising edge.
  task automatic run_scn(input string name, input int ncyc, input int reset_at,
                         input bit chk_done, input int sd4, input int kd4,
                         input int sd3, input int kd3, input int nsd4);
    int fs4 = -1, fk4 = -1, fs3 = -1, fk3 = -1, cnt_sd4 = 0;
    obs_t o4, o3;
    build_model(ncyc);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      drive(rq_s[c], rq_k[c]);
      @(negedge clk);
      o4 = get_obs(4);
      o3 = get_obs(3);
      cmp($sformatf("%s L4 c%0d", name, c), o4, model_obs(4, c));
      cmp($sformatf("%s L3 c%0d", name, c), o3, model_obs(3, c));
      if (o4.sd === 1'b1) begin cnt_sd4++; if (fs4 < 0) fs4 = c; end
      if (o4.kd === 1'b1 && fk4 < 0) fk4 = c;
      if (o3.sd === 1'b1 && fs3 < 0) fs3 = c;
      if (o3.kd === 1'b1 && fk3 < 0) fk3 = c;
      if (c == reset_at) begin
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0);
        #1;
        cmp($sformatf("%s async reset L4", name), get_obs(4), '0);
        cmp($sformatf("%s async reset L3", name), get_obs(3), '0);
        break;
      end
    end
    drive(1'b0, 1'b0);
    if (chk_done) begin
      check({name, " first state_done L4"}, 32'(fs4), 32'(sd4));
      check({name, " first key_done L4"},   32'(fk4), 32'(kd4));
      check({name, " first state_done L3"}, 32'(fs3), 32'(sd3));
      check({name, " first key_done L3"},   32'(fk3), 32'(kd3));
      check({name, " state_done count L4"}, 32'(cnt_sd4), 32'(nsd4));
    end
  endtask

  initial begin
    drive(1'b0, 1'b0);

    // State batch alone.
    clear_stim();
    rq_s[0] = 1'b1;
    run_scn("state_only", 30, -1, 1'b1, 20, -1, 19, -1, 1);

    // State and key in the same cycle: key first, state follows with no gap.
    clear_stim();
    rq_s[0] = 1'b1;
    rq_k[0] = 1'b1;
    run_scn("both_same", 34, -1, 1'b1, 24, 8, 23, 7, 1);

    // Key request during a state batch waits for the batch to finish.
    clear_stim();
    rq_s[0]  = 1'b1;
    rq_k[10] = 1'b1;
    run_scn("key_during_state", 32, -1, 1'b1, 20, 24, 19, 23, 1);

    // Second state request while issuing is dropped and flags overrun.
    clear_stim();
    rq_s[0] = 1'b1;
    rq_s[5] = 1'b1;
    run_scn("state_overrun", 34, -1, 1'b1, 20, -1, 19, -1, 1);

    // Reset in the middle of a batch.
    clear_stim();
    rq_s[0] = 1'b1;
    run_scn("reset_mid", 30, 8, 1'b1, -1, -1, -1, -1, 0);

    // Restart after the aborted batch begins again from index 0.
    clear_stim();
    rq_s[0] = 1'b1;
    run_scn("restart", 30, -1, 1'b1, 20, -1, 19, -1, 1);

    // Random request streams against the schedule model.
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int c = 0; c < 260; c++) begin
        rq_s[c] = ($urandom_range(0, 9) == 0);
        rq_k[c] = ($urandom_range(0, 7) == 0);
      end
      run_scn($sformatf("random%0d", r), 300, -1, 1'b0, 0, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
